// File: rtl/anim_scheduler.sv
// rtl/anim_scheduler.sv - sprite animation scheduler with move/attack/cooldown FSM
module anim_scheduler #(
   parameter int FRAME_W        = 46,
   parameter int ROW_H          = 46,
   parameter int COOLDOWN_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        anim_tick,
   input  logic [1:0]  move_state,
   input  logic        atk_req,
   input  logic        atk_abort,
   output logic [1:0]  anim_id,
   output logic [2:0]  frame,
   output logic [10:0] anim_row,
   output logic [10:0] anim_col,
   output logic [5:0]  max_width,
   output logic        frame_start,
   output logic        atk_active,
   output logic        hitbox_active,
   output logic        atk_done
);

   localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_TICKS - 1);

   localparam logic [1:0] ID_IDLE = 2'd0;
   localparam logic [1:0] ID_WALK = 2'd1;
   localparam logic [1:0] ID_JUMP = 2'd2;
   localparam logic [1:0] ID_ATK  = 2'd3;

   typedef enum logic [1:0] {
      ST_MOVE     = 2'd0,
      ST_ATTACK   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [1:0]      id_n;
   logic [2:0]      frame_n;
   logic [2:0]      hold_cnt, hold_n;
   logic [CD_W-1:0] cd_cnt, cd_n;
   logic            fs_n, done_n, atk_n, hit_n;
   logic [1:0]      move_id;
   logic            expire, restart, advance;
   logic [1:0]      restart_id;

   // Index of the last frame of each animation.
   function automatic logic [2:0] last_frame(input logic [1:0] id);
      case (id)
         ID_IDLE: last_frame = 3'd3;
         ID_WALK: last_frame = 3'd5;
         ID_JUMP: last_frame = 3'd2;
         default: last_frame = 3'd4;
      endcase
   endfunction

   // Hold length minus one for a given animation and frame.
   function automatic logic [2:0] hold_last(input logic [1:0] id, input logic [2:0] fr);
      case (id)
         ID_IDLE: hold_last = 3'd7;
         ID_WALK: hold_last = 3'd3;
         ID_JUMP: hold_last = 3'd5;
         default: begin
            if (fr <= 3'd1)      hold_last = 3'd1;
            else if (fr <= 3'd3) hold_last = 3'd2;
            else                 hold_last = 3'd3;
         end
      endcase
   endfunction

   // Movement code 3 is shown as IDLE.
   assign move_id = (move_state == 2'd3) ? ID_IDLE : move_state;
   assign expire  = anim_tick && (hold_cnt == hold_last(anim_id, frame));

   // Next-state, animation bookkeeping and registered-output values.
   always_comb begin
      state_n    = state;
      id_n       = anim_id;
      frame_n    = frame;
      hold_n     = hold_cnt;
      cd_n       = cd_cnt;
      fs_n       = 1'b0;
      done_n     = 1'b0;
      restart    = 1'b0;
      restart_id = anim_id;
      advance    = 1'b0;
      case (state)
         ST_MOVE: begin
            if (atk_req) begin
               state_n    = ST_ATTACK;
               restart    = 1'b1;
               restart_id = ID_ATK;
            end else if (move_id != anim_id) begin
               restart    = 1'b1;
               restart_id = move_id;
            end else begin
               advance = anim_tick;
            end
         end
         ST_ATTACK: begin
            if (atk_abort) begin
               state_n    = ST_MOVE;
               restart    = 1'b1;
               restart_id = move_id;
            end else if (expire && frame == 3'd4) begin
               state_n    = ST_COOLDOWN;
               done_n     = 1'b1;
               cd_n       = '0;
               restart    = 1'b1;
               restart_id = move_id;
            end else begin
               advance = anim_tick;
            end
         end
         ST_COOLDOWN: begin
            if (anim_tick) begin
               if (cd_cnt == CD_LAST) begin
                  state_n = ST_MOVE;
                  cd_n    = '0;
               end else begin
                  cd_n = cd_cnt + 1'b1;
               end
            end
            if (move_id != anim_id) begin
               restart    = 1'b1;
               restart_id = move_id;
            end else begin
               advance = anim_tick;
            end
         end
         default: state_n = ST_MOVE;
      endcase

      if (restart) begin
         id_n    = restart_id;
         frame_n = 3'd0;
         hold_n  = 3'd0;
         fs_n    = 1'b1;
      end else if (advance) begin
         if (expire) begin
            hold_n = 3'd0;
            if (frame != last_frame(anim_id)) begin
               frame_n = frame + 3'd1;
               fs_n    = 1'b1;
            end else if (anim_id != ID_JUMP) begin
               frame_n = 3'd0;
               fs_n    = 1'b1;
            end
         end else begin
            hold_n = hold_cnt + 3'd1;
         end
      end

      atk_n = (state_n == ST_ATTACK);
      hit_n = atk_n && (frame_n == 3'd2 || frame_n == 3'd3);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_MOVE;
         anim_id       <= ID_IDLE;
         frame         <= 3'd0;
         hold_cnt      <= 3'd0;
         cd_cnt        <= '0;
         frame_start   <= 1'b0;
         atk_done      <= 1'b0;
         atk_active    <= 1'b0;
         hitbox_active <= 1'b0;
      end else begin
         state         <= state_n;
         anim_id       <= id_n;
         frame         <= frame_n;
         hold_cnt      <= hold_n;
         cd_cnt        <= cd_n;
         frame_start   <= fs_n;
         atk_done      <= done_n;
         atk_active    <= atk_n;
         hitbox_active <= hit_n;
      end
   end

   assign anim_row  = 11'(anim_id) * 11'(ROW_H);
   assign anim_col  = 11'(frame) * 11'(FRAME_W);
   assign max_width = 6'(FRAME_W);

endmodule

// File: tb/tb_anim_scheduler.sv
// tb/tb_anim_scheduler.sv - self-checking bench for anim_scheduler
module tb_anim_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        anim_tick = 1'b0;
   logic [1:0]  move_state = 2'd0;
   logic        atk_req = 1'b0;
   logic        atk_abort = 1'b0;
   logic [1:0]  anim_id;
   logic [2:0]  frame;
   logic [10:0] anim_row, anim_col;
   logic [5:0]  max_width;
   logic        frame_start, atk_active, hitbox_active, atk_done;

   anim_scheduler dut (
      .clk(clk), .reset(reset), .anim_tick(anim_tick), .move_state(move_state),
      .atk_req(atk_req), .atk_abort(atk_abort), .anim_id(anim_id), .frame(frame),
      .anim_row(anim_row), .anim_col(anim_col), .max_width(max_width),
      .frame_start(frame_start), .atk_active(atk_active),
      .hitbox_active(hitbox_active), .atk_done(atk_done)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int fs_cnt = 0;
   bit done_seen = 0;

   // Behavioural model: phase 0 move, 1 attack, 2 cooldown; ticks_left counts down per frame.
   int hold_tab[4][6];
   int nfr[4];
   int m_ph, m_id, m_fr, m_left, m_cd;
   bit m_fs, m_done;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_restart(input int id);
      m_id = id;
      m_fr = 0;
      m_left = hold_tab[id][0];
      m_fs = 1;
   endtask

   task automatic m_tick_anim();
      m_left--;
      if (m_left == 0) begin
         if (m_fr == nfr[m_id] - 1) begin
            if (m_id == 2) begin
               m_left = hold_tab[2][2];
            end else begin
               m_fr = 0;
               m_left = hold_tab[m_id][0];
               m_fs = 1;
            end
         end else begin
            m_fr++;
            m_left = hold_tab[m_id][m_fr];
            m_fs = 1;
         end
      end
   endtask

   task automatic model_update();
      int dec;
      dec = (move_state == 2'd1) ? 1 : (move_state == 2'd2) ? 2 : 0;
      m_fs = 0;
      m_done = 0;
      if (reset) begin
         m_ph = 0; m_id = 0; m_fr = 0; m_left = hold_tab[0][0]; m_cd = 0;
      end else if (m_ph == 0) begin
         if (atk_req) begin
            m_ph = 1;
            m_restart(3);
         end else if (dec != m_id) m_restart(dec);
         else if (anim_tick) m_tick_anim();
      end else if (m_ph == 1) begin
         if (atk_abort) begin
            m_ph = 0;
            m_restart(dec);
         end else if (anim_tick && m_fr == 4 && m_left == 1) begin
            m_done = 1;
            m_ph = 2;
            m_cd = 4;
            m_restart(dec);
         end else if (anim_tick) m_tick_anim();
      end else begin
         if (anim_tick) begin
            m_cd--;
            if (m_cd == 0) m_ph = 0;
         end
         if (dec != m_id) m_restart(dec);
         else if (anim_tick) m_tick_anim();
      end
   endtask

   task automatic check_all();
      cmp("anim_id", 32'(anim_id), 32'(m_id));
      cmp("frame", 32'(frame), 32'(m_fr));
      cmp("anim_row", 32'(anim_row), 32'(m_id * 46));
      cmp("anim_col", 32'(anim_col), 32'(m_fr * 46));
      cmp("max_width", 32'(max_width), 32'd46);
      cmp("frame_start", 32'(frame_start), 32'(m_fs));
      cmp("atk_active", 32'(atk_active), 32'(m_ph == 1));
      cmp("hitbox_active", 32'(hitbox_active), 32'(m_ph == 1 && (m_fr == 2 || m_fr == 3)));
      cmp("atk_done", 32'(atk_done), 32'(m_done));
   endtask

   // One clock: inputs at negedge, model advanced, outputs checked 1ns after posedge.
   task automatic step(input logic t);
      @(negedge clk);
      anim_tick = t;
      model_update();
      @(posedge clk);
      #1;
      anim_tick = 1'b0;
      if (frame_start) fs_cnt++;
      if (atk_done) done_seen = 1;
      check_all();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         step(1'b0);
      end
   endtask

   function automatic int atk_frame_at(input int k);
      if (k < 2) return 0;
      if (k < 4) return 1;
      if (k < 7) return 2;
      if (k < 10) return 3;
      return 4;
   endfunction

   initial begin
      nfr = '{4, 6, 3, 5};
      for (int a = 0; a < 4; a++)
         for (int f = 0; f < 6; f++)
            hold_tab[a][f] = 0;
      for (int f = 0; f < 4; f++) hold_tab[0][f] = 8;
      for (int f = 0; f < 6; f++) hold_tab[1][f] = 4;
      for (int f = 0; f < 3; f++) hold_tab[2][f] = 6;
      hold_tab[3][0] = 2; hold_tab[3][1] = 2; hold_tab[3][2] = 3;
      hold_tab[3][3] = 3; hold_tab[3][4] = 4;
      m_ph = 0; m_id = 0; m_fr = 0; m_left = 8; m_cd = 0; m_fs = 0; m_done = 0;

      // Reset state.
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      cmp("rst_anim_id", 32'(anim_id), 0);
      cmp("rst_anim_col", 32'(anim_col), 0);
      cmp("rst_frame_start", 32'(frame_start), 0);
      reset = 1'b0;

      // Idle loop: 8 ticks per frame, four frames.
      move_state = 2'd0;
      fs_cnt = 0;
      run_ticks(8);
      cmp("idle8_frame", 32'(frame), 1);
      cmp("idle8_col", 32'(anim_col), 46);
      cmp("model_idle8_frame", 32'(m_fr), 1);
      run_ticks(24);
      cmp("idle32_frame", 32'(frame), 0);
      cmp("idle32_fs_count", 32'(fs_cnt), 4);

      // Move change with coincident tick restarts without counting the tick.
      run_ticks(21);
      move_state = 2'd1;
      step(1'b1);
      cmp("walk_id", 32'(anim_id), 1);
      cmp("walk_frame", 32'(frame), 0);
      cmp("walk_row", 32'(anim_row), 46);
      cmp("walk_col", 32'(anim_col), 0);
      cmp("walk_fs", 32'(frame_start), 1);
      step(1'b0);
      run_ticks(4);
      cmp("walk4_frame", 32'(frame), 1);

      // Jump holds last frame forever.
      move_state = 2'd2;
      step(1'b0);
      run_ticks(12);
      cmp("jump12_frame", 32'(frame), 2);
      fs_cnt = 0;
      run_ticks(30);
      cmp("jump42_frame", 32'(frame), 2);
      cmp("jump_no_fs", 32'(fs_cnt), 0);

      // Full attack, then cooldown ignoring atk_req for four ticks.
      move_state = 2'd0;
      step(1'b0);
      atk_req = 1'b1;
      step(1'b0);
      atk_req = 1'b0;
      cmp("atk_accept_active", 32'(atk_active), 1);
      cmp("atk_accept_id", 32'(anim_id), 3);
      for (int k = 1; k <= 14; k++) begin
         step(1'b1);
         if (k < 14) begin
            cmp("atk_frame", 32'(frame), 32'(atk_frame_at(k)));
            cmp("atk_hitbox", 32'(hitbox_active),
                32'(atk_frame_at(k) == 2 || atk_frame_at(k) == 3));
         end else begin
            cmp("atk_done_pulse", 32'(atk_done), 1);
            cmp("atk_end_active", 32'(atk_active), 0);
            cmp("atk_end_id", 32'(anim_id), 0);
         end
         step(1'b0);
      end
      for (int k = 1; k <= 4; k++) begin
         atk_req = 1'b1;
         step(1'b1);
         atk_req = 1'b0;
         cmp("cooldown_ignore", 32'(atk_active), 0);
         step(1'b0);
      end
      atk_req = 1'b1;
      step(1'b1);
      atk_req = 1'b0;
      cmp("cooldown_then_accept", 32'(atk_active), 1);

      // Abort during frame 3; move_state change ignored while attacking.
      move_state = 2'd1;
      run_ticks(7);
      cmp("abort_pre_frame", 32'(frame), 3);
      cmp("abort_pre_id", 32'(anim_id), 3);
      done_seen = 0;
      atk_abort = 1'b1;
      step(1'b0);
      atk_abort = 1'b0;
      cmp("abort_active", 32'(atk_active), 0);
      cmp("abort_hitbox", 32'(hitbox_active), 0);
      cmp("abort_id", 32'(anim_id), 1);
      cmp("abort_frame", 32'(frame), 0);
      run_ticks(3);
      cmp("abort_no_done", 32'(done_seen), 0);
      atk_abort = 1'b1;
      atk_req = 1'b1;
      step(1'b0);
      atk_abort = 1'b0;
      atk_req = 1'b0;
      cmp("req_with_abort_in_move", 32'(atk_active), 1);

      // Abort coincident with final-frame expiry wins.
      run_ticks(13);
      cmp("final_frame", 32'(frame), 4);
      atk_abort = 1'b1;
      step(1'b1);
      atk_abort = 1'b0;
      cmp("final_abort_done", 32'(atk_done), 0);
      cmp("final_abort_active", 32'(atk_active), 0);
      cmp("final_abort_id", 32'(anim_id), 1);
      atk_req = 1'b1;
      step(1'b0);
      atk_req = 1'b0;
      cmp("final_abort_is_move", 32'(atk_active), 1);

      // Reset mid-attack on frame 2.
      run_ticks(4);
      cmp("pre_reset_hitbox", 32'(hitbox_active), 1);
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
      cmp("midrst_id", 32'(anim_id), 0);
      cmp("midrst_frame", 32'(frame), 0);
      cmp("midrst_active", 32'(atk_active), 0);
      cmp("midrst_hitbox", 32'(hitbox_active), 0);
      cmp("midrst_done", 32'(atk_done), 0);
      cmp("midrst_fs", 32'(frame_start), 0);
      step(1'b0);

      // Code 3 as idle, and move changes during cooldown.
      move_state = 2'd3;
      run_ticks(3);
      atk_req = 1'b1;
      step(1'b0);
      atk_req = 1'b0;
      move_state = 2'd2;
      run_ticks(14);
      move_state = 2'd1;
      run_ticks(2);
      move_state = 2'd3;
      run_ticks(6);
      cmp("tail_id", 32'(anim_id), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/anim_scheduler.md
ANIM_SCHEDULER -- requirements
Module: anim_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning): FRAME_W, 46, sprite cell width in pixels; ROW_H, 46, sprite row height in pixels; COOLDOWN_TICKS, 4, anim_ticks of post-attack lockout.
REQ-002 SHALL have ports (name, direction, width, meaning) as listed in REQ-003 to REQ-014.
REQ-003 clk, in, 1, single system clock; all state updates on its rising edge.
REQ-004 reset, in, 1, synchronous, active-high reset.
REQ-005 anim_tick, in, 1, one-clk-wide frame-rate pulse, synchronous to clk.
REQ-006 move_state, in, 2, movement encoding: 0 IDLE, 1 WALK, 2 JUMP, 3 treated as IDLE.
REQ-007 atk_req, in, 1, neutral-attack request, level sampled each clk.
REQ-008 atk_abort, in, 1, cancels an in-progress attack, for example when hit.
REQ-009 anim_id, out, 2, animation shown: 0 IDLE, 1 WALK, 2 JUMP, 3 ATK_NEUTRAL.
REQ-010 frame, out, 3, current frame index within anim_id.
REQ-011 anim_row, out, 11, equals anim_id*ROW_H; anim_col, out, 11, equals frame*FRAME_W; max_width, out, 6, constant FRAME_W.
REQ-012 frame_start, out, 1, one-clk pulse whenever frame or anim_id changes, including restarts.
REQ-013 atk_active, out, 1, high while in ATTACK; hitbox_active, out, 1, high in ATTACK on frames 2 and 3 only.
REQ-014 atk_done, out, 1, one-clk pulse on normal attack completion.

Function
REQ-015 SHALL hold fixed animation tables with frame count, hold ticks per frame and end behaviour:
- IDLE: 4 frames, 8 ticks each, loops.
- WALK: 6 frames, 4 ticks each, loops.
- JUMP: 3 frames, 6 ticks each, holds frame 2 indefinitely.
- ATK_NEUTRAL: 5 frames with holds 2, 2, 3, 3, 4, one-shot.
REQ-016 SHALL implement FSM states MOVE, ATTACK and COOLDOWN.
REQ-017 SHALL count anim_ticks in a hold counter: on a tick, if hold_cnt equals hold-1 then advance frame and clear hold_cnt; otherwise increment hold_cnt. Frame 0 is therefore shown for exactly hold ticks after any restart.
REQ-018 SHALL define restart as frame=0, hold_cnt=0 and frame_start=1, applied at the same clk edge as the triggering condition; a coincident anim_tick is not counted.
REQ-019 In MOVE and COOLDOWN, anim_id SHALL track move_state; any change of the decoded move_state from anim_id triggers a restart.
REQ-020 In MOVE, atk_req=1 SHALL transition to ATTACK with anim_id=3 and a restart, and atk_active=1 from the next cycle.
REQ-021 In ATTACK, move_state changes SHALL be ignored; after the hold of frame 4 expires: atk_done pulse, enter COOLDOWN, restart on the decoded move_state.
REQ-022 In COOLDOWN, atk_req SHALL be ignored with no queuing; after COOLDOWN_TICKS anim_ticks the FSM enters MOVE with no animation restart.
REQ-023 atk_abort in ATTACK SHALL cause: enter MOVE (not COOLDOWN), no atk_done, restart on move_state, atk_active=0 and hitbox_active=0 next cycle.
REQ-024 atk_abort SHALL have no effect in MOVE or COOLDOWN; atk_req together with atk_abort in MOVE SHALL be accepted.
REQ-025 atk_abort on the same cycle as the final-frame expiry SHALL win: no atk_done, no COOLDOWN.
REQ-026 All state and outputs SHALL be registered except anim_row, anim_col and max_width, which are combinational from registered anim_id and frame with no added latency; products fit 11 bits (max 3*46=138, 5*46=230).

Reset
REQ-027 reset=1 at a clk edge SHALL force: state MOVE, anim_id=0, frame=0, hold_cnt=0, cooldown count=0, atk_active=0, hitbox_active=0, atk_done=0, frame_start=0, anim_row=0, anim_col=0.
REQ-028 reset SHALL take priority over all inputs, including mid-attack, and SHALL suppress atk_done.

Verification
REQ-029 After reset with move_state=0: 8 ticks give frame=1 and anim_col=46; 32 ticks give frame=0 again, with a frame_start pulse at each change.
REQ-030 IDLE at frame 2 with hold_cnt 5, then move_state=1 together with anim_tick: next cycle anim_id=1, frame=0, anim_row=46, anim_col=0, frame_start=1; 4 more ticks give frame=1.
REQ-031 move_state=2: after 12 ticks frame=2; after 30 further ticks frame is still 2 with no further frame_start.
REQ-032 atk_req in MOVE: frames 0,1,2,3,4 at cumulative ticks 0,2,4,7,10; hitbox_active only on frames 2 and 3; atk_done on tick 14; then COOLDOWN, where atk_req is ignored for 4 ticks and accepted on the 5th.
REQ-033 atk_abort asserted during ATTACK frame 3: next cycle atk_active=0, hitbox_active=0, anim_id=move_state, frame=0; atk_done never pulses; an immediate atk_req is accepted.
REQ-034 reset asserted during ATTACK frame 2: next cycle all outputs match REQ-027 and atk_done stays 0.
